// File: rtl/bpi_cmd_seq.sv
// BPI flash command sequencer: turns unlock/erase/program/read-status commands into flash word accesses.
// Optional macro BPI_CMD_SEQ_TIMEOUT_EN bounds each status poll phase to C_POLL_LIMIT reads.
module bpi_cmd_seq #(
  parameter int unsigned C_ADDR_WIDTH = 26,
  parameter int unsigned C_MEM_WIDTH  = 16,
  parameter int unsigned C_POLL_LIMIT = 1048576
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [C_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_MEM_WIDTH-1:0]  cmd_data,
  output logic                    done_valid,
  output logic [7:0]              done_status,
  output logic                    done_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [C_ADDR_WIDTH-1:0] mem_addr,
  output logic [C_MEM_WIDTH-1:0]  mem_wdata,
  input  logic                    mem_ack,
  input  logic [C_MEM_WIDTH-1:0]  mem_rdata
);

  typedef enum logic [2:0] {IDLE, WR1, WR2, POLL, CLR, ARRAY, DONE} state_t;
  typedef enum logic [1:0] {OP_UNLOCK, OP_ERASE, OP_PROG, OP_STAT} op_t;

  state_t                  state_q, state_d;
  op_t                     op_q;
  logic [C_ADDR_WIDTH-1:0] addr_q;
  logic [C_MEM_WIDTH-1:0]  data_q;
  logic [7:0]              status_q;
  logic                    err_q;

  logic                    acked;
  logic                    issue;
  logic                    iss_we;
  logic [C_MEM_WIDTH-1:0]  iss_wdata;
  logic                    stat_ld;
  logic                    err_set;

`ifdef BPI_CMD_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = (C_POLL_LIMIT > 1) ? $clog2(C_POLL_LIMIT) : 1;
  logic [CNT_W-1:0] poll_cnt;
  logic             poll_inc;
  logic             unused_bits;
  assign unused_bits = ^mem_rdata[C_MEM_WIDTH-1:8];
`else
  logic             unused_bits;
  assign unused_bits = ^{mem_rdata[C_MEM_WIDTH-1:8], 1'(C_POLL_LIMIT)};
`endif

  function automatic logic [C_MEM_WIDTH-1:0] code(input logic [7:0] c);
    code      = '0;
    code[7:0] = c;
  endfunction

  assign acked      = mem_req & mem_ack;
  assign cmd_ready  = (state_q == IDLE) && !rst;
  assign done_valid = (state_q == DONE) && !rst;

  // Each access state raises mem_req only while it is low; because the state advances
  // on the ack edge, the next access always sees exactly one idle cycle first.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    iss_we    = 1'b1;
    iss_wdata = '0;
    stat_ld   = 1'b0;
    err_set   = 1'b0;
`ifdef BPI_CMD_SEQ_TIMEOUT_EN
    poll_inc  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) state_d = WR1;
      end
      WR1: begin
        issue = !mem_req;
        case (op_q)
          OP_UNLOCK: iss_wdata = code(8'h60);
          OP_ERASE:  iss_wdata = code(8'h20);
          OP_PROG:   iss_wdata = code(8'h40);
          default:   iss_wdata = code(8'h70);
        endcase
        if (acked) state_d = (op_q == OP_STAT) ? POLL : WR2;
      end
      WR2: begin
        issue     = !mem_req;
        iss_wdata = (op_q == OP_PROG) ? data_q : code(8'hD0);
        if (acked) state_d = (op_q == OP_UNLOCK) ? ARRAY : POLL;
      end
      POLL: begin
        issue  = !mem_req;
        iss_we = 1'b0;
        if (acked) begin
          if (op_q == OP_STAT) begin
            stat_ld = 1'b1;
            state_d = ARRAY;
          end else if (mem_rdata[7]) begin
            stat_ld = 1'b1;
            if (|mem_rdata[5:1]) begin
              err_set = 1'b1;
              state_d = CLR;
            end else begin
              state_d = ARRAY;
            end
          end
`ifdef BPI_CMD_SEQ_TIMEOUT_EN
          else if (poll_cnt == CNT_W'(C_POLL_LIMIT - 1)) begin
            stat_ld = 1'b1;
            err_set = 1'b1;
            state_d = CLR;
          end else begin
            poll_inc = 1'b1;
          end
`endif
        end
      end
      CLR: begin
        issue     = !mem_req;
        iss_wdata = code(8'h50);
        if (acked) state_d = ARRAY;
      end
      ARRAY: begin
        issue     = !mem_req;
        iss_wdata = code(8'hFF);
        if (acked) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_UNLOCK;
      addr_q      <= '0;
      data_q      <= '0;
      status_q    <= '0;
      err_q       <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      done_status <= '0;
      done_err    <= 1'b0;
`ifdef BPI_CMD_SEQ_TIMEOUT_EN
      poll_cnt    <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cmd_valid) begin
        op_q     <= op_t'(cmd_op);
        addr_q   <= cmd_addr;
        data_q   <= cmd_data;
        status_q <= 8'h80;
        err_q    <= 1'b0;
`ifdef BPI_CMD_SEQ_TIMEOUT_EN
        poll_cnt <= '0;
`endif
      end
      if (issue) begin
        mem_req   <= 1'b1;
        mem_we    <= iss_we;
        mem_addr  <= addr_q;
        mem_wdata <= iss_wdata;
      end else if (acked) begin
        mem_req <= 1'b0;
      end
      if (stat_ld) status_q <= mem_rdata[7:0];
      if (err_set) err_q <= 1'b1;
`ifdef BPI_CMD_SEQ_TIMEOUT_EN
      if (poll_inc) poll_cnt <= poll_cnt + 1'b1;
`endif
      // Completion results only change as the final access finishes, so they hold across idle.
      if (state_q == ARRAY && acked) begin
        done_status <= status_q;
        done_err    <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_bpi_cmd_seq.sv
// Directed table-driven bench for bpi_cmd_seq with a behavioural flash responder.
module tb_bpi_cmd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [25:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic        done_valid;
  logic [7:0]  done_status;
  logic        done_err;
  logic        mem_req;
  logic        mem_we;
  logic [25:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  bpi_cmd_seq #(
    .C_ADDR_WIDTH(26),
    .C_MEM_WIDTH (16),
    .C_POLL_LIMIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .done_valid (done_valid),
    .done_status(done_status),
    .done_err   (done_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef logic [7:0][16:0] acc_t;
  typedef struct {
    logic [1:0]       op;
    logic [25:0]      addr;
    logic [15:0]      data;
    int unsigned      n_rd;
    logic [2:0][7:0]  rd;
    logic [7:0]       def_rd;
    int unsigned      dly;
    int unsigned      n_acc;
    acc_t             acc;
    logic [7:0]       st;
    logic             err;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned n_done = 0;
  int unsigned stab_err = 0;
  int unsigned gap_err = 0;

  // responder controls and access log
  int unsigned ack_dly = 0;
  logic [7:0]  def_rd = 8'h80;
  logic [7:0]  rdq[$];
  bit          spur = 1'b0;
  logic        acc_we[$];
  logic [25:0] acc_addr[$];
  logic [15:0] acc_wd[$];

  vec_t vecs[8];
  int unsigned n_vec;

  localparam logic [16:0] RD = 17'h0;
  localparam logic [16:0] NO = 17'h0;

  function automatic logic [16:0] W(input logic [15:0] d);
    W = {1'b1, d};
  endfunction

  function automatic acc_t L(input logic [16:0] a0, a1, a2, a3, a4, a5, a6, a7);
    L[0] = a0; L[1] = a1; L[2] = a2; L[3] = a3;
    L[4] = a4; L[5] = a5; L[6] = a6; L[7] = a7;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (done_valid) n_done++;
    end
  end

  // Flash model: logs each request, checks field stability and the post-ack gap.
  initial begin
    bit          in_req;
    bit          spur_ack;
    int unsigned cnt;
    logic        l_we;
    logic [25:0] l_addr;
    logic [15:0] l_wd;
    in_req = 1'b0; spur_ack = 1'b0; cnt = 0;
    l_we = 1'b0; l_addr = '0; l_wd = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        if (mem_req && !spur_ack) gap_err++;
        spur_ack = 1'b0;
      end else if (mem_req) begin
        if (!in_req) begin
          in_req = 1'b1;
          cnt = ack_dly;
          l_we = mem_we; l_addr = mem_addr; l_wd = mem_wdata;
          acc_we.push_back(mem_we);
          acc_addr.push_back(mem_addr);
          acc_wd.push_back(mem_wdata);
        end else if (mem_we !== l_we || mem_addr !== l_addr || mem_wdata !== l_wd) begin
          stab_err++;
        end
        if (cnt == 0) begin
          mem_ack = 1'b1;
          if (!mem_we) mem_rdata = {8'h00, (rdq.size() > 0) ? rdq.pop_front() : def_rd};
          in_req = 1'b0;
        end else begin
          cnt--;
        end
      end else begin
        in_req = 1'b0;
        if (spur) begin
          mem_ack = 1'b1;
          spur = 1'b0;
          spur_ack = 1'b1;
        end
      end
    end
  end

  task automatic start_cmd(input logic [1:0] op, input logic [25:0] addr, input logic [15:0] data,
                           output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("cmd_ready_wait", 32'(ok), 32'd1);
    if (ok) begin
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic apply_vec(input int unsigned i);
    vec_t v;
    bit   ok;
    bit   got;
    v = vecs[i];
    ack_dly = v.dly;
    def_rd = v.def_rd;
    rdq.delete();
    for (int unsigned k = 0; k < v.n_rd; k++) rdq.push_back(v.rd[k]);
    acc_we.delete(); acc_addr.delete(); acc_wd.delete();
    start_cmd(v.op, v.addr, v.data, ok);
    if (!ok) return;
    got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (done_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk($sformatf("v%0d done_seen", i), 32'(got), 32'd1);
    if (!got) return;
    chk($sformatf("v%0d done_status", i), 32'(done_status), 32'(v.st));
    chk($sformatf("v%0d done_err", i), 32'(done_err), 32'(v.err));
    chk($sformatf("v%0d ready_in_done", i), 32'(cmd_ready), 32'd0);
    chk($sformatf("v%0d n_access", i), acc_we.size(), v.n_acc);
    for (int unsigned k = 0; k < v.n_acc; k++) begin
      if (k < acc_we.size()) begin
        chk($sformatf("v%0d acc%0d we", i, k), 32'(acc_we[k]), 32'(v.acc[k][16]));
        chk($sformatf("v%0d acc%0d addr", i, k), 32'(acc_addr[k]), 32'(v.addr));
        if (v.acc[k][16]) chk($sformatf("v%0d acc%0d wdata", i, k), 32'(acc_wd[k]), 32'(v.acc[k][15:0]));
      end
    end
    @(posedge clk);
    #1;
    chk($sformatf("v%0d done_one_cycle", i), 32'(done_valid), 32'd0);
    chk($sformatf("v%0d ready_after", i), 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    bit          ok;
    bit          seen;
    bit          any_req;
    int unsigned nd;

    vecs[0] = '{op:2'd0, addr:26'h0010000, data:16'h0000, n_rd:0, rd:24'h0, def_rd:8'h80, dly:0,
                n_acc:3, acc:L(W(16'h60), W(16'hD0), W(16'hFF), NO, NO, NO, NO, NO), st:8'h80, err:1'b0};
    vecs[1] = '{op:2'd2, addr:26'h0000123, data:16'hA5A5, n_rd:3, rd:{8'h80, 8'h00, 8'h00}, def_rd:8'h80, dly:0,
                n_acc:6, acc:L(W(16'h40), W(16'hA5A5), RD, RD, RD, W(16'hFF), NO, NO), st:8'h80, err:1'b0};
    vecs[2] = '{op:2'd1, addr:26'h0020000, data:16'h0000, n_rd:1, rd:{8'h00, 8'h00, 8'hA0}, def_rd:8'h80, dly:0,
                n_acc:5, acc:L(W(16'h20), W(16'hD0), RD, W(16'h50), W(16'hFF), NO, NO, NO), st:8'hA0, err:1'b1};
    vecs[3] = '{op:2'd3, addr:26'h0000055, data:16'h0000, n_rd:1, rd:{8'h00, 8'h00, 8'h12}, def_rd:8'h80, dly:0,
                n_acc:3, acc:L(W(16'h70), RD, W(16'hFF), NO, NO, NO, NO, NO), st:8'h12, err:1'b0};
    vecs[4] = '{op:2'd2, addr:26'h3FFFFFF, data:16'h0001, n_rd:0, rd:24'h0, def_rd:8'h80, dly:5,
                n_acc:4, acc:L(W(16'h40), W(16'h0001), RD, W(16'hFF), NO, NO, NO, NO), st:8'h80, err:1'b0};
    vecs[5] = '{op:2'd1, addr:26'h0000200, data:16'h0000, n_rd:1, rd:{8'h00, 8'h00, 8'h82}, def_rd:8'h80, dly:0,
                n_acc:5, acc:L(W(16'h20), W(16'hD0), RD, W(16'h50), W(16'hFF), NO, NO, NO), st:8'h82, err:1'b1};
    vecs[6] = '{op:2'd1, addr:26'h0000300, data:16'h0000, n_rd:1, rd:{8'h00, 8'h00, 8'hC1}, def_rd:8'h80, dly:0,
                n_acc:4, acc:L(W(16'h20), W(16'hD0), RD, W(16'hFF), NO, NO, NO, NO), st:8'hC1, err:1'b0};
    n_vec = 7;
`ifdef BPI_CMD_SEQ_TIMEOUT_EN
    vecs[7] = '{op:2'd1, addr:26'h0000040, data:16'h0000, n_rd:0, rd:24'h0, def_rd:8'h00, dly:0,
                n_acc:8, acc:L(W(16'h20), W(16'hD0), RD, RD, RD, RD, W(16'h50), W(16'hFF)), st:8'h00, err:1'b1};
    n_vec = 8;
`endif

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst done_valid", 32'(done_valid), 32'd0);
    chk("rst done_status", 32'(done_status), 32'd0);
    chk("rst done_err", 32'(done_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst cmd_ready", 32'(cmd_ready), 32'd1);

    for (int unsigned i = 0; i < n_vec; i++) apply_vec(i);

    // completion results hold while idle
    repeat (5) @(posedge clk);
    #1;
    chk("hold done_status", 32'(done_status), 32'(vecs[n_vec-1].st));
    chk("hold done_err", 32'(done_err), 32'(vecs[n_vec-1].err));

    // reset while the WR2 request is outstanding
    ack_dly = 20;
    acc_we.delete(); acc_addr.delete(); acc_wd.delete();
    nd = n_done;
    start_cmd(2'd0, 26'h0010000, 16'h0000, ok);
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (acc_we.size() == 2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("midrst wr2_seen", 32'(seen), 32'd1);
    @(negedge clk);
    chk("midrst req_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst req_dropped", 32'(mem_req), 32'd0);
    chk("midrst ready_in_rst", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst ready_after", 32'(cmd_ready), 32'd1);
    spur = 1'b1;
    any_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (mem_req || !cmd_ready) any_req = 1'b1;
    end
    chk("midrst stray_ack_ignored", 32'(any_req), 32'd0);
    chk("midrst no_done", n_done, nd);
    ack_dly = 0;
    apply_vec(0);

    chk("req_field_stability", stab_err, 0);
    chk("req_gap_after_ack", gap_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
